// File: rtl/riscv_pkg.sv
// Shared definitions for the execute stage: ALU op codes, control-bit positions,
// divider FSM states and packed pipeline-register width helpers.
package riscv_pkg;

  // ctrl[6:0] = {src_b_imm, src_a_pc, muldiv, alu_op[3:0]}; bits above pass through.
  localparam int CTRL_LOW_BITS  = 7;
  localparam int CTRL_SRC_B_IMM = 6;
  localparam int CTRL_SRC_A_PC  = 5;
  localparam int CTRL_MULDIV    = 4;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_SRA    = 4'b1101;
  localparam logic [3:0] ALU_OR     = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  // With muldiv set, alu_op[2] selects divide; [1] picks remainder, [0] unsigned.
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam int DIV_OP_BIT       = 2;
  localparam int DIV_REM_BIT      = 1;
  localparam int DIV_UNSIGNED_BIT = 0;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  function automatic int id_exc_width(input int reg_width, input int reg_bits,
                                      input int ctrl_size);
    return reg_bits + 1 + ctrl_size + 4 * reg_width;
  endfunction

  function automatic int exc_mem_width(input int reg_width, input int reg_bits,
                                       input int ctrl_size);
    return reg_bits + 1 + (ctrl_size - CTRL_LOW_BITS) + 3 * reg_width;
  endfunction

endpackage

// File: rtl/execute_if.sv
// Pipeline-register bundle between decode, execute and memory stages.
interface execute_if #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int CTRL_SIZE = 21,
  parameter int REG_BITS  = $clog2(REG_COUNT)
);
  localparam int ID_W = riscv_pkg::id_exc_width(REG_WIDTH, REG_BITS, CTRL_SIZE);
  localparam int EX_W = riscv_pkg::exc_mem_width(REG_WIDTH, REG_BITS, CTRL_SIZE);

  logic [ID_W-1:0] id_exc_reg;
  logic            flush;
  logic            stall_out;
  logic [EX_W-1:0] exc_mem_reg;

  modport master (output id_exc_reg, output flush, input stall_out, input exc_mem_reg);
  modport slave  (input id_exc_reg, input flush, output stall_out, output exc_mem_reg);
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle over sign-stripped
// magnitudes, signs reapplied on the way out.
module seq_divider
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] quo_q, rem_q, dsr_q;
  logic             neg_quo_q, neg_rem_q, zero_q;

  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH:0]   shifted, trial;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dsr_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dsr_mag = dsr_neg ? -divisor : divisor;

  // trial[WIDTH] is the borrow: set when the divisor does not fit this step.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rstn) begin
      state     <= DIV_IDLE;
      count     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start && !abort) begin
            state     <= DIV_BUSY;
            count     <= '0;
            quo_q     <= dvd_mag;
            rem_q     <= '0;
            dsr_q     <= dsr_mag;
            neg_quo_q <= dvd_neg ^ dsr_neg;
            neg_rem_q <= dvd_neg;
            zero_q    <= (divisor == '0);
          end
        end
        DIV_BUSY: begin
          if (abort) begin
            state <= DIV_IDLE;
          end else begin
            quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            rem_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            count <= count + CNT_W'(1);
            if (count == LAST) state <= DIV_DONE;
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);

  // Divide by zero leaves the dividend in rem_q, so only the quotient needs forcing.
  assign quotient  = zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
  assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/execute.sv
// Execute stage: ALU, optional multiplier and iterative divider (EXECUTE_MULDIV_EN),
// registered into exc_mem_reg with bubble insertion on flush and divide stalls.
module execute
  import riscv_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int CTRL_SIZE = 21,
  parameter int REG_BITS  = $clog2(REG_COUNT)
) (
  input logic      clk,
  input logic      rstn,
  execute_if.slave bus
);
  localparam int EX_W = exc_mem_width(REG_WIDTH, REG_BITS, CTRL_SIZE);

  logic [REG_BITS-1:0]  rd;
  logic                 write_en;
  logic [CTRL_SIZE-1:0] ctrl;
  logic [REG_WIDTH-1:0] rs1_data, rs2_data, imm, pc;

  assign {rd, write_en, ctrl, rs1_data, rs2_data, imm, pc} = bus.id_exc_reg;

  logic [3:0] alu_op;
  logic       muldiv;
  logic [REG_WIDTH-1:0] op_a, op_b;
  logic [4:0] shamt;

  assign alu_op = ctrl[3:0];
  assign muldiv = ctrl[CTRL_MULDIV];
  assign op_a   = ctrl[CTRL_SRC_A_PC] ? pc : rs1_data;
  assign op_b   = ctrl[CTRL_SRC_B_IMM] ? imm : rs2_data;
  assign shamt  = op_b[4:0];

  logic [REG_WIDTH-1:0] alu_res, alu_out;

  always_comb begin
    // NOTE: default first so no path through the case can infer a latch.
    alu_res = '0;
    case (alu_op)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_SLL:    alu_res = op_a << shamt;
      ALU_SLT:    alu_res = {{(REG_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   alu_res = {{(REG_WIDTH-1){1'b0}}, op_a < op_b};
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_SRL:    alu_res = op_a >> shamt;
      ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
      ALU_OR:     alu_res = op_a | op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_PASS_B: alu_res = op_b;
      default:    alu_res = '0;
    endcase
  end

  logic bubble;

`ifdef EXECUTE_MULDIV_EN
  // Operands widened to 2*REG_WIDTH with per-op sign extension; the modular
  // product then holds the exact signed/unsigned result in both halves.
  logic [2*REG_WIDTH-1:0] mul_a, mul_b, product;
  logic                   mul_a_signed, mul_b_signed;
  logic [REG_WIDTH-1:0]   mul_res, div_res, quotient, remainder;
  logic                   div_req, div_busy, div_done;

  assign mul_a_signed = (alu_op[2:0] == MD_MULH) || (alu_op[2:0] == MD_MULHSU);
  assign mul_b_signed = (alu_op[2:0] == MD_MULH);
  assign mul_a   = {{REG_WIDTH{mul_a_signed & op_a[REG_WIDTH-1]}}, op_a};
  assign mul_b   = {{REG_WIDTH{mul_b_signed & op_b[REG_WIDTH-1]}}, op_b};
  assign product = mul_a * mul_b;
  assign mul_res = (alu_op[2:0] == MD_MUL) ? product[REG_WIDTH-1:0]
                                           : product[2*REG_WIDTH-1:REG_WIDTH];

  assign div_req = muldiv & alu_op[DIV_OP_BIT];

  seq_divider #(.WIDTH(REG_WIDTH)) u_div (
    .clk       (clk),
    .rstn      (rstn),
    .start     (div_req),
    .abort     (bus.flush),
    .is_signed (~alu_op[DIV_UNSIGNED_BIT]),
    .dividend  (op_a),
    .divisor   (op_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign div_res = alu_op[DIV_REM_BIT] ? remainder : quotient;
  assign alu_out = muldiv ? (div_req ? div_res : mul_res) : alu_res;

  // Upstream holds the divide until DONE, when the result is written.
  assign bus.stall_out = rstn & ~bus.flush & (div_busy | (div_req & ~div_done));
  assign bubble        = bus.flush | (div_req & ~div_done);
`else
  assign alu_out       = muldiv ? '0 : alu_res;
  assign bus.stall_out = 1'b0;
  assign bubble        = bus.flush;
`endif

  logic [EX_W-1:0] result_word;

  assign result_word = {rd, write_en, ctrl[CTRL_SIZE-1:CTRL_LOW_BITS], alu_out, rs2_data,
                        pc + REG_WIDTH'(4)};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       bus.exc_mem_reg <= '0;
    else if (bubble) bus.exc_mem_reg <= '0;
    else             bus.exc_mem_reg <= result_word;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameter REG_WIDTH, 32, datapath width.
REQ-002 Parameter REG_COUNT, 32, architectural register count.
REQ-003 Parameter CTRL_SIZE, 21, decoded control bits per instruction.
REQ-004 Parameter REG_BITS, $clog2(REG_COUNT), destination-register index width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 id_exc_reg  input  REG_BITS+1+CTRL_SIZE+4*REG_WIDTH  packed {rd, write_en, ctrl[CTRL_SIZE-1:0], rs1_data, rs2_data, imm, pc}, MSB first.
REQ-008 flush  input  1  kill the instruction currently in execute.
REQ-009 stall_out  output  1  upstream holds id_exc_reg stable while high.
REQ-010 exc_mem_reg  output  REG_BITS+1+(CTRL_SIZE-7)+3*REG_WIDTH  packed {rd, write_en, ctrl[CTRL_SIZE-1:7], alu_out, rs2_data, return_pc}, MSB first.

Function
REQ-011 ctrl[6:0] SHALL decode as {src_b_imm, src_a_pc, muldiv, alu_op[3:0]}; ctrl[CTRL_SIZE-1:7] SHALL pass through unmodified.
REQ-012 Operand A SHALL be pc when src_a_pc, else rs1_data; operand B SHALL be imm when src_b_imm, else rs2_data.
REQ-013 alu_op (muldiv=0): 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND, 1111 pass B; other codes SHALL produce 0.
REQ-014 Shift amount SHALL be B[4:0]; all arithmetic SHALL be modulo 2^REG_WIDTH.
REQ-015 return_pc SHALL equal pc+4 (modulo 2^REG_WIDTH).
REQ-016 Non-divide operations SHALL have 1-cycle latency: exc_mem_reg is registered at the edge following presentation; stall_out stays 0.
REQ-017 muldiv=1 with alu_op[2:0] 000/001/010/011 (MUL/MULH/MULHSU/MULHU) SHALL complete in 1 cycle with a combinational product.
REQ-018 muldiv=1 with alu_op[2:0] 100/101/110/111 (DIV/DIVU/REM/REMU) SHALL use the iterative divider FSM: IDLE, BUSY, DONE.
REQ-019 IDLE with divide presented: stall_out=1 combinationally; next edge latches operands, clears counter, goes to BUSY, and writes a bubble.
REQ-020 BUSY: one quotient bit per cycle, stall_out=1, bubble each edge; after 32 cycles goes to DONE.
REQ-021 DONE: stall_out=0; next edge registers the result into exc_mem_reg and returns to IDLE (total 33 stall cycles, result on 34th edge).
REQ-022 Bubble SHALL be exc_mem_reg all zeros (write_en=0, mem_read=0, mem_write=0).
REQ-023 Divide by zero SHALL give quotient all-ones and remainder = dividend; signed overflow (-2^31 / -1) SHALL give quotient -2^31 and remainder 0.
REQ-024 flush=1 SHALL force stall_out=0, write a bubble at the next edge, and return the FSM to IDLE; flush wins over DONE.
REQ-025 Back-to-back divides SHALL each take the full sequence; no result forwarding between them.

Reset
REQ-026 rstn low SHALL immediately clear exc_mem_reg to 0, FSM to IDLE, counter and divider registers to 0; stall_out SHALL be 0 while rstn is low.
REQ-027 Reset during BUSY SHALL abandon the divide; no result SHALL be emitted.

Configuration
REQ-028 Macro EXECUTE_MULDIV_EN defined: REQ-017..REQ-025 divide/multiply behaviour compiled in.
REQ-029 Macro EXECUTE_MULDIV_EN undefined: no multiplier, divider or FSM; muldiv=1 SHALL give alu_out 0 in 1 cycle; stall_out tied 0; flush still bubbles.

Structure
REQ-030 Shared package riscv_pkg SHALL hold alu_op codes, ctrl bit positions, the FSM state enum and packed-field width constants.
REQ-031 The iterative divider SHALL be a sub-module seq_divider (start, operands, signed flag -> busy, done, quotient, remainder).

Verification
REQ-032 ADD rs1=5, imm=-3, src_b_imm -> alu_out=2, return_pc=pc+4, one edge later.
REQ-033 SRA rs1=0x80000000, rs2=4 -> alu_out=0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1.
REQ-034 DIV -7/2 -> stall_out high 33 cycles, then quotient -3; REM same operands -> -1.
REQ-035 DIVU 10/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0; DIV same operands -> 0x80000000.
REQ-036 flush at BUSY cycle 10 -> bubble next edge, stall_out 0, following ADD completes in 1 cycle.
REQ-037 rstn low at BUSY cycle 5 -> exc_mem_reg 0 immediately; after release, FSM IDLE, no stale result.
